// File: rtl/cam_capture_st.sv
// cam_capture_st: captures frames from a parallel camera bus, assembles
// BPP-byte pixels, optionally decimates, and streams them out over Avalon-ST.
// Ports:
//   clk_clk, reset_reset_n        : system clock, asynchronous active-low reset
//   cam_pclk, cam_vsync, cam_href : raw camera timing (asynchronous to clk_clk)
//   cam_data                      : raw camera byte
//   enable, decim, clear_status   : capture enable, decimation mode, overflow clear
//   out_data/valid/ready/sop/eop  : Avalon-ST pixel stream
//   overflow, frame_count         : sticky drop flag, completed-frame counter
module cam_capture_st #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned BPP        = 2,
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  input  logic                  cam_pclk,
  input  logic                  cam_vsync,
  input  logic                  cam_href,
  input  logic [DATA_W-1:0]     cam_data,
  input  logic                  enable,
  input  logic [1:0]            decim,
  input  logic                  clear_status,
  output logic [BPP*DATA_W-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic                  overflow,
  output logic [15:0]           frame_count
);

  localparam int unsigned PIX_W  = BPP * DATA_W;
  localparam int unsigned WORD_W = PIX_W + 2;
  localparam int unsigned BC_W   = (BPP > 1) ? $clog2(BPP) : 1;
  localparam int unsigned X_W    = $clog2(H_ACTIVE + 1);
  localparam int unsigned Y_W    = $clog2(V_ACTIVE + 1);
  localparam int unsigned AW     = $clog2(FIFO_DEPTH);
  localparam int unsigned CW     = AW + 1;

  typedef enum logic [1:0] {IDLE, WAIT_SOF, ACTIVE, DROP} state_t;

  state_t state, state_nx;
  logic   sof;

  // Two-flop synchronisers plus one extra stage on the timing lines for edge detection
  logic pclk_m, pclk_s, pclk_d;
  logic vs_m, vs_s, vs_d;
  logic href_m, href_s, href_d;
  logic [DATA_W-1:0] data_m, data_s;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      pclk_m <= 1'b0; pclk_s <= 1'b0; pclk_d <= 1'b0;
      vs_m   <= 1'b0; vs_s   <= 1'b0; vs_d   <= 1'b0;
      href_m <= 1'b0; href_s <= 1'b0; href_d <= 1'b0;
      data_m <= '0;   data_s <= '0;
    end else begin
      pclk_m <= cam_pclk;  pclk_s <= pclk_m; pclk_d <= pclk_s;
      vs_m   <= cam_vsync; vs_s   <= vs_m;   vs_d   <= vs_s;
      href_m <= cam_href;  href_s <= href_m; href_d <= href_s;
      data_m <= cam_data;  data_s <= data_m;
    end
  end

  logic strobe, vs_rise, vs_fall, href_fall;
  assign strobe    = pclk_s & ~pclk_d;
  assign vs_rise   = vs_s & ~vs_d;
  assign vs_fall   = ~vs_s & vs_d;
  assign href_fall = ~href_s & href_d;

  // Pixel assembly, position tracking and keep/marker decisions
  logic [BC_W-1:0]   bcnt;
  logic [PIX_W-1:0]  shreg, pix_word;
  logic [X_W-1:0]    x;
  logic [Y_W-1:0]    y;
  logic [1:0]        m;
  logic              sop_pend;
  logic              accept, pix_done, keep, is_eop;

  assign accept   = (state == ACTIVE) & strobe & href_s;
  assign pix_done = accept & (bcnt == BC_W'(BPP - 1));
  // Earlier bytes shift toward the MS end; the final byte lands in the LS byte
  assign pix_word = PIX_W'({shreg, data_s});
  assign keep     = (x < X_W'(H_ACTIVE)) && (y < Y_W'(V_ACTIVE)) &&
                    ((x & X_W'(m)) == '0) && ((y & Y_W'(m)) == '0);
  assign is_eop   = (32'(x) + 32'(m) == H_ACTIVE - 1) &&
                    (32'(y) + 32'(m) == V_ACTIVE - 1);

  logic              push_q;
  logic [WORD_W-1:0] push_word;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      bcnt      <= '0;
      shreg     <= '0;
      x         <= '0;
      y         <= '0;
      m         <= 2'b00;
      sop_pend  <= 1'b0;
      push_q    <= 1'b0;
      push_word <= '0;
    end else begin
      if (sof || href_fall)         bcnt <= '0;
      else if (accept)              bcnt <= pix_done ? '0 : BC_W'(bcnt + 1'b1);
      if (accept)                   shreg <= pix_word;
      if (sof || href_fall)         x <= '0;
      else if (pix_done && (x < X_W'(H_ACTIVE))) x <= X_W'(x + 1'b1);
      if (sof)                      y <= '0;
      else if (href_fall && (state == ACTIVE) && (y < Y_W'(V_ACTIVE))) y <= Y_W'(y + 1'b1);
      if (sof) begin
        case (decim)
          2'b01:   m <= 2'b01;
          2'b10:   m <= 2'b11;
          default: m <= 2'b00;
        endcase
      end
      if (sof)                      sop_pend <= 1'b1;
      else if (pix_done && keep)    sop_pend <= 1'b0;
      push_q <= pix_done & keep;
      if (pix_done)                 push_word <= {pix_word, sop_pend, is_eop};
    end
  end

  // Show-ahead FIFO; the head entry is mirrored in registered outputs
  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count, count_nx;
  logic              pop, full, push_ok, ovf_evt, eop_push;
  logic [WORD_W-1:0] head_nx;

  assign pop      = out_valid & out_ready;
  assign full     = (count == CW'(FIFO_DEPTH));
  assign push_ok  = push_q & (~full | pop);
  assign ovf_evt  = push_q & full & ~pop;
  assign eop_push = push_ok & push_word[0];
  assign count_nx = CW'(count + CW'(push_ok) - CW'(pop));

  always_comb begin
    head_nx = {out_data, out_sop, out_eop};
    if (push_ok && ((count == '0) || ((count == CW'(1)) && pop)))
      head_nx = push_word;
    else if (pop && (count > CW'(1)))
      head_nx = mem[AW'(rd_ptr + AW'(1))];
  end

  always_ff @(posedge clk_clk) begin
    if (push_ok) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      out_data    <= '0;
      out_sop     <= 1'b0;
      out_eop     <= 1'b0;
      out_valid   <= 1'b0;
      overflow    <= 1'b0;
      frame_count <= '0;
    end else begin
      if (push_ok) wr_ptr <= AW'(wr_ptr + AW'(1));
      if (pop)     rd_ptr <= AW'(rd_ptr + AW'(1));
      count <= count_nx;
      {out_data, out_sop, out_eop} <= head_nx;
      out_valid   <= (count_nx != '0);
      // A new drop wins over a simultaneous clear
      overflow    <= (overflow & ~clear_status) | ovf_evt;
      frame_count <= frame_count + 16'(eop_push);
    end
  end

  // Capture FSM
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state <= IDLE;
    else                state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    sof      = 1'b0;
    case (state)
      IDLE:     if (enable) state_nx = WAIT_SOF;
      WAIT_SOF: begin
        if (!enable) state_nx = IDLE;
        else if (vs_fall) begin
          state_nx = ACTIVE;
          sof      = 1'b1;
        end
      end
      ACTIVE: begin
        // enable is only honoured at frame end so a frame is never truncated
        if (ovf_evt)       state_nx = DROP;
        else if (eop_push) state_nx = enable ? WAIT_SOF : IDLE;
        else if (vs_rise)  state_nx = WAIT_SOF;
      end
      DROP:     if (vs_rise) state_nx = WAIT_SOF;
      default:  state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cam_capture_st.sv
// tb_cam_capture_st: randomized self-checking bench for cam_capture_st.
// A behavioural camera drives frames; an expected word list is computed from
// frame geometry and decimation rules and compared against captured output.
`timescale 1ns/1ps
module tb_cam_capture_st;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned BPP    = 2;
  localparam int unsigned H      = 8;
  localparam int unsigned V      = 4;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned PW     = BPP * DATA_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              pclk = 1'b0, vsync = 1'b0, href = 1'b0;
  logic [DATA_W-1:0] cdata = '0;
  logic              enable = 1'b0;
  logic [1:0]        decim = 2'b00;
  logic              clear_status = 1'b0;
  logic [PW-1:0]     out_data;
  logic              out_valid, out_sop, out_eop, overflow;
  logic              out_ready = 1'b0;
  logic [15:0]       frame_count;

  int total = 0;
  int bad   = 0;
  int exp_fc = 0;
  int ready_mode = 0;   // 0 always ready, 1 random, 2 stalled

  logic [PW+1:0] exp_q[$];
  logic [PW+1:0] rx_q[$];
  logic [PW-1:0] pix [0:V][0:H+1];

  cam_capture_st #(
    .DATA_W(DATA_W), .BPP(BPP), .H_ACTIVE(H), .V_ACTIVE(V), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .cam_pclk(pclk), .cam_vsync(vsync), .cam_href(href), .cam_data(cdata),
    .enable(enable), .decim(decim), .clear_status(clear_status),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sop(out_sop), .out_eop(out_eop),
    .overflow(overflow), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  // Sink: chooses ready and records each transfer, all on the falling edge
  always @(negedge clk) begin
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 1) == 1);
      default: out_ready = 1'b0;
    endcase
    if (rst_n && out_valid && out_ready) rx_q.push_back({out_data, out_sop, out_eop});
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: kept pixels in raster order, SOP on the first, EOP at the last
  // decimated position; nothing after EOP belongs to this frame.
  task automatic build_exp(input int lines, input int ppl, input logic [1:0] d, output bit got_eop);
    int st;
    bit first;
    bit e;
    st = (d == 2'b01) ? 2 : (d == 2'b10) ? 4 : 1;
    first = 1'b1;
    got_eop = 1'b0;
    for (int yy = 0; yy < lines; yy++)
      for (int xx = 0; xx < ppl; xx++)
        if (!got_eop && xx < H && yy < V && (xx % st) == 0 && (yy % st) == 0) begin
          e = (xx == H - st) && (yy == V - st);
          exp_q.push_back({pix[yy][xx], first, e});
          first = 1'b0;
          if (e) got_eop = 1'b1;
        end
  endtask

  task automatic fill_rand();
    for (int yy = 0; yy <= V; yy++)
      for (int xx = 0; xx < H + 2; xx++) pix[yy][xx] = PW'($urandom);
  endtask

  task automatic cam_byte(input logic [DATA_W-1:0] b);
    cdata = b;
    repeat (3) @(negedge clk);
    pclk = 1'b1;
    repeat (3) @(negedge clk);
    pclk = 1'b0;
  endtask

  task automatic cam_line(input int yy, input int ppl);
    logic [PW-1:0] p;
    href = 1'b1;
    repeat (2) @(negedge clk);
    for (int xx = 0; xx < ppl; xx++) begin
      p = pix[yy][xx];
      for (int b = 0; b < BPP; b++) cam_byte(p[PW-1-DATA_W*b -: DATA_W]);
    end
    href = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic vsync_pulse();
    vsync = 1'b1;
    repeat (8) @(negedge clk);
    vsync = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic cam_frame(input int lines, input int ppl);
    vsync_pulse();
    for (int yy = 0; yy < lines; yy++) cam_line(yy, ppl);
  endtask

  task automatic wait_rx(input int n);
    for (int i = 0; i < 400 && rx_q.size() < n; i++) @(negedge clk);
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({out_valid, out_sop, out_eop, overflow} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags got %b want 0000", {out_valid, out_sop, out_eop, overflow});
    end
    total++;
    if (out_data !== '0) begin bad++; $display("FAIL reset_data got %h want 0", out_data); end
    total++;
    if (frame_count !== 16'd0) begin bad++; $display("FAIL reset_fc got %0d want 0", frame_count); end
    rst_n = 1'b1;
    enable = 1'b1;
    repeat (4) @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL post_reset_valid got %b want 0", out_valid); end
  endtask

  task automatic test_latency();
    logic [PW-1:0] p;
    fill_rand();
    exp_q.delete(); rx_q.delete();
    ready_mode = 0;
    decim = 2'b00;
    vsync_pulse();
    href = 1'b1;
    repeat (2) @(negedge clk);
    p = pix[0][0];
    cam_byte(p[PW-1 -: DATA_W]);
    cdata = p[DATA_W-1:0];
    repeat (3) @(negedge clk);
    pclk = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL latency_early got %b want 0", out_valid); end
    pclk = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL latency_edge got %b want 1", out_valid); end
    href = 1'b0;
    exp_q.push_back({p, 1'b1, 1'b0});
    wait_rx(1);
    total++;
    if (rx_q.size() != 1) begin bad++; $display("FAIL latency_count got %0d want 1", rx_q.size()); end
    else begin
      total++;
      if (rx_q[0] !== exp_q[0]) begin bad++; $display("FAIL latency_word got %h want %h", rx_q[0], exp_q[0]); end
    end
  endtask

  task automatic test_full_frame();
    bit e;
    fill_rand();
    exp_q.delete(); rx_q.delete();
    ready_mode = 0;
    decim = 2'b00;
    build_exp(V, H, 2'b00, e);
    if (e) exp_fc++;
    cam_frame(V, H);
    wait_rx(exp_q.size());
    total++;
    if (rx_q.size() != exp_q.size()) begin
      bad++; $display("FAIL full_count got %0d want %0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      total++;
      if (rx_q[i] !== exp_q[i]) begin bad++; $display("FAIL full_word%0d got %h want %h", i, rx_q[i], exp_q[i]); end
    end
    total++;
    if (frame_count !== 16'(exp_fc)) begin bad++; $display("FAIL full_fc got %0d want %0d", frame_count, exp_fc); end
    total++;
    if (overflow !== 1'b0) begin bad++; $display("FAIL full_ovf got %b want 0", overflow); end
  endtask

  task automatic test_decim();
    bit e;
    logic [1:0] modes [3];
    modes[0] = 2'b01; modes[1] = 2'b10; modes[2] = 2'b11;
    for (int k = 0; k < 3; k++) begin
      if (modes[k] == 2'b01) begin
        for (int yy = 0; yy <= V; yy++)
          for (int xx = 0; xx < H + 2; xx++) pix[yy][xx] = {8'(yy), 8'(xx)};
      end else fill_rand();
      exp_q.delete(); rx_q.delete();
      ready_mode = 1;
      decim = modes[k];
      build_exp(V + 1, H + 2, modes[k], e);
      if (e) exp_fc++;
      cam_frame(V + 1, H + 2);
      wait_rx(exp_q.size());
      total++;
      if (rx_q.size() != exp_q.size()) begin
        bad++; $display("FAIL decim%0d_count got %0d want %0d", modes[k], rx_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
        total++;
        if (rx_q[i] !== exp_q[i]) begin
          bad++; $display("FAIL decim%0d_word%0d got %h want %h", modes[k], i, rx_q[i], exp_q[i]);
        end
      end
      total++;
      if (frame_count !== 16'(exp_fc)) begin bad++; $display("FAIL decim%0d_fc got %0d want %0d", modes[k], frame_count, exp_fc); end
      total++;
      if (overflow !== 1'b0) begin bad++; $display("FAIL decim%0d_ovf got %b want 0", modes[k], overflow); end
    end
    ready_mode = 0;
    decim = 2'b00;
  endtask

  task automatic test_overflow();
    bit e;
    fill_rand();
    exp_q.delete(); rx_q.delete();
    ready_mode = 2;
    build_exp(V, H, 2'b00, e);
    while (exp_q.size() > DEPTH) void'(exp_q.pop_back());
    cam_frame(V, H);
    repeat (20) @(negedge clk);
    total++;
    if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got %b want 1", overflow); end
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL ovf_valid got %b want 1", out_valid); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({out_data, out_sop, out_eop} !== exp_q[0]) begin
        bad++; $display("FAIL ovf_hold%0d got %h want %h", i, {out_data, out_sop, out_eop}, exp_q[0]);
      end
      @(negedge clk);
    end
    total++;
    if (frame_count !== 16'(exp_fc)) begin bad++; $display("FAIL ovf_fc got %0d want %0d", frame_count, exp_fc); end
    clear_status = 1'b1;
    @(negedge clk);
    clear_status = 1'b0;
    @(negedge clk);
    total++;
    if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got %b want 0", overflow); end
    ready_mode = 0;
    wait_rx(DEPTH);
    total++;
    if (rx_q.size() != DEPTH) begin bad++; $display("FAIL ovf_count got %0d want %0d", rx_q.size(), DEPTH); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      total++;
      if (rx_q[i] !== exp_q[i]) begin bad++; $display("FAIL ovf_word%0d got %h want %h", i, rx_q[i], exp_q[i]); end
    end
    test_full_frame();
  endtask

  task automatic test_abort();
    bit e;
    fill_rand();
    exp_q.delete(); rx_q.delete();
    ready_mode = 0;
    build_exp(V - 1, H, 2'b00, e);
    cam_frame(V - 1, H);
    wait_rx(exp_q.size());
    total++;
    if (rx_q.size() != exp_q.size()) begin
      bad++; $display("FAIL abort_count got %0d want %0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      total++;
      if (rx_q[i] !== exp_q[i]) begin bad++; $display("FAIL abort_word%0d got %h want %h", i, rx_q[i], exp_q[i]); end
    end
    total++;
    if (frame_count !== 16'(exp_fc)) begin bad++; $display("FAIL abort_fc got %0d want %0d", frame_count, exp_fc); end
    test_full_frame();
  endtask

  task automatic test_enable_drop();
    bit e;
    fill_rand();
    exp_q.delete(); rx_q.delete();
    ready_mode = 0;
    build_exp(V, H, 2'b00, e);
    if (e) exp_fc++;
    vsync_pulse();
    cam_line(0, H);
    enable = 1'b0;
    for (int yy = 1; yy < V; yy++) cam_line(yy, H);
    wait_rx(exp_q.size());
    total++;
    if (rx_q.size() != exp_q.size()) begin
      bad++; $display("FAIL endrop_count got %0d want %0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      total++;
      if (rx_q[i] !== exp_q[i]) begin bad++; $display("FAIL endrop_word%0d got %h want %h", i, rx_q[i], exp_q[i]); end
    end
    total++;
    if (frame_count !== 16'(exp_fc)) begin bad++; $display("FAIL endrop_fc got %0d want %0d", frame_count, exp_fc); end
    rx_q.delete();
    cam_frame(V, H);
    repeat (20) @(negedge clk);
    total++;
    if (rx_q.size() != 0) begin bad++; $display("FAIL endrop_idle got %0d words want 0", rx_q.size()); end
    total++;
    if (frame_count !== 16'(exp_fc)) begin bad++; $display("FAIL endrop_idle_fc got %0d want %0d", frame_count, exp_fc); end
    enable = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    fill_rand();
    exp_q.delete(); rx_q.delete();
    ready_mode = 2;
    vsync_pulse();
    fork
      cam_line(0, H);
      begin
        repeat (45) @(negedge clk);
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL rstmid_pre_valid got %b want 1", out_valid); end
        rst_n = 1'b0;
        #1;
        total++;
        if ({out_valid, out_sop, out_eop, overflow} !== 4'b0000) begin
          bad++; $display("FAIL rstmid_flags got %b want 0000", {out_valid, out_sop, out_eop, overflow});
        end
        total++;
        if (out_data !== '0) begin bad++; $display("FAIL rstmid_data got %h want 0", out_data); end
        total++;
        if (frame_count !== 16'd0) begin bad++; $display("FAIL rstmid_fc got %0d want 0", frame_count); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
      end
    join
    exp_fc = 0;
    ready_mode = 0;
    repeat (20) @(negedge clk);
    total++;
    if (rx_q.size() != 0) begin bad++; $display("FAIL rstmid_flush got %0d words want 0", rx_q.size()); end
    test_full_frame();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_full_frame();
    test_decim();
    test_overflow();
    test_abort();
    test_enable_drop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cam_capture_st.md
CAM_CAPTURE_ST -- requirements
Module: cam_capture_st

Interface
REQ-001 Parameter DATA_W, default 8, camera bus width in bits.
REQ-002 Parameter BPP, default 2, camera bytes per pixel (1..4); the first byte received goes in the MS byte.
REQ-003 Parameter H_ACTIVE, default 640, pixels per line.
REQ-004 Parameter V_ACTIVE, default 480, lines per frame.
REQ-005 Parameter FIFO_DEPTH, default 16, output FIFO entries; power of 2, at least 4.
REQ-006 Port clk_clk  in  1  sole clock; all logic is synchronous to its rising edge.
REQ-007 Port reset_reset_n  in  1  asynchronous, active-low reset.
REQ-008 Ports cam_pclk, cam_vsync, cam_href  in  1 each  raw camera timing inputs, asynchronous to clk_clk.
REQ-009 Port cam_data  in  DATA_W  raw camera byte.
REQ-010 Port enable  in  1  capture enable.
REQ-011 Port decim  in  2  decimation mode: 00 = 1:1, 01 = 1:2, 10 = 1:4, 11 = reserved and treated as 00.
REQ-012 Port clear_status  in  1  single-cycle pulse that clears overflow.
REQ-013 Port out_data  out  BPP*DATA_W  pixel word.
REQ-014 Ports out_valid  out  1, and out_ready  in  1: Avalon-ST handshake.
REQ-015 Ports out_sop, out_eop  out  1 each  frame start and frame end markers, qualified by out_valid.
REQ-016 Port overflow  out  1  sticky flag: a pixel was dropped.
REQ-017 Port frame_count  out  16  count of completed frames.

Function
REQ-018 cam_pclk, cam_vsync, cam_href and cam_data each SHALL pass through 2-flop synchronisers; the sample strobe SHALL be a 1-cycle pulse on the synchronised cam_pclk rising edge; cam_pclk frequency SHALL be at most clk_clk/4.
REQ-019 FSM states: IDLE, WAIT_SOF, ACTIVE, DROP.
- IDLE -> WAIT_SOF when enable=1.
- WAIT_SOF -> ACTIVE on the synchronised vsync falling edge; decim is latched at this transition.
- ACTIVE -> WAIT_SOF on the EOP push, or IDLE instead if enable=0.
- ACTIVE -> DROP on overflow.
- DROP -> WAIT_SOF on a vsync rising edge.
REQ-020 A vsync rising edge in ACTIVE SHALL abort the frame: no EOP is issued, and the FSM goes to WAIT_SOF.
REQ-021 Bytes SHALL be accepted only on strobe cycles in ACTIVE with synchronised href=1; the byte counter wraps at BPP, and each wrap completes one pixel.
REQ-022 Column counter x SHALL count completed pixels within a line and reset on the href falling edge; pixels with x >= H_ACTIVE SHALL be discarded.
REQ-023 Line counter y SHALL increment on each href falling edge in ACTIVE and reset on SOF; lines with y >= V_ACTIVE SHALL be discarded.
REQ-024 With m = 0, 1 or 3 for decim 00, 01 or 10, a pixel SHALL be kept iff (x & m)==0 and (y & m)==0.
REQ-025 out_sop SHALL be set on the first kept pixel of a frame; out_eop SHALL be set on the kept pixel where x = H_ACTIVE-1-m and y = V_ACTIVE-1-m.
REQ-026 The FIFO SHALL be a show-ahead FIFO of width BPP*DATA_W+2; a word transfers on out_valid & out_ready.
REQ-027 With the FIFO empty, out_valid SHALL rise exactly 2 clk cycles after the strobe cycle carrying the pixel's final byte.
REQ-028 A push to a full FIFO SHALL drop the pixel, set overflow, and enter DROP; a simultaneous pop and push while full SHALL count as not full.
REQ-029 out_data and out_valid SHALL be independent of out_ready (no combinational path); out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-030 frame_count SHALL increment, wrapping at 0xFFFF, when an EOP word is pushed.
REQ-031 If clear_status and a new overflow occur in the same cycle, overflow SHALL read 1.
REQ-032 enable=0 mid-frame SHALL NOT truncate the frame in progress.

Reset
REQ-033 Reset asserted SHALL immediately force: FSM=IDLE, all counters 0, FIFO empty, out_valid=0, out_sop=0, out_eop=0, out_data=0, overflow=0, frame_count=0, synchronisers 0.
REQ-034 Reset asserted mid-frame SHALL discard all buffered pixels; after release, capture SHALL resume only from the next vsync falling edge.

Verification
REQ-035 Scenario: BPP=2, H=4, V=2, decim=00, out_ready=1, one frame of bytes 0x01..0x10 -> 8 words 0x0102..0x0F10; SOP on 0x0102; EOP on 0x0F10; frame_count=1.
REQ-036 Scenario: H=8, V=4, decim=01, pixel value = {y,x} -> 8 words (x,y in {0,2,4,6}x{0,2}); EOP on x=6, y=2.
REQ-037 Scenario: out_ready=0 for a full frame with FIFO_DEPTH=4 -> 4 words held, overflow=1, no EOP, frame_count unchanged; the next frame is captured complete with SOP.
REQ-038 Scenario: vsync rises after 3 lines of a V=4 frame -> no EOP, frame_count unchanged; the next frame is normal.
REQ-039 Scenario: reset pulse mid-line -> all outputs 0 within the same cycle; the first word after release carries SOP.
REQ-040 Scenario: enable dropped mid-frame -> the frame completes with EOP, then the FSM enters IDLE and no further words are produced.
